// File: rtl/uart_pkg.sv
// Shared types and oversampling constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned MID_SAMPLE  = 7;
    localparam int unsigned LAST_SAMPLE = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx_in;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, DATA_LEN data bits LSB first, parity, stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_LEN    = 8,
    parameter int unsigned PARITY_TYPE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_tick_rx,
    input  logic                rx_in,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                rx_busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_LEN);

    localparam logic [CW-1:0] TICK_MID  = CW'(MID_SAMPLE);
    localparam logic [CW-1:0] TICK_LAST = CW'(LAST_SAMPLE);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_LEN - 1);

    rx_state_t           state;
    logic                rx_s;
    logic                prev;
    logic [CW-1:0]       tick_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DATA_LEN-1:0] shift_reg;
    logic                par_bit;
    logic                exp_par;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rx_in (rx_in),
        .rx_s  (rx_s)
    );

    assign exp_par = (PARITY_TYPE != 0) ? ^shift_reg : ~^shift_reg;
    assign rx_busy = (state != RX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            prev       <= 1'b1;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (baud_tick_rx) begin
                case (state)
                    RX_IDLE: begin
                        prev <= rx_s;
                        if (prev && !rx_s) begin
                            state    <= RX_START;
                            tick_cnt <= '0;
                        end
                    end
                    RX_START: begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= RX_DATA;
                                bit_cnt <= '0;
                            end else begin
                                // Start bit gone by mid-bit: treat as a glitch.
                                state <= RX_IDLE;
                                prev  <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == TICK_LAST) begin
                            shift_reg <= {rx_s, shift_reg[DATA_LEN-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                state <= RX_PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == TICK_LAST) begin
                            par_bit <= rx_s;
                            state   <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == TICK_LAST) begin
                            state      <= RX_IDLE;
                            // A low stop bit leaves prev low, so a stuck line cannot re-trigger.
                            prev       <= rx_s;
                            rx_data    <= shift_reg;
                            parity_err <= (par_bit != exp_par);
                            frame_err  <= ~rx_s;
                            rx_valid   <= 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bench-side serializer, expected-word scoreboards per DUT.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick_rx = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_in_odd = 1'b1;

    logic [7:0] rx_data, rx_data_o;
    logic       rx_valid, rx_valid_o;
    logic       parity_err, parity_err_o;
    logic       frame_err, frame_err_o;
    logic       rx_busy, rx_busy_o;

    uart_rx #(.DATA_LEN(8), .PARITY_TYPE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick_rx (baud_tick_rx),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    uart_rx #(.DATA_LEN(8), .PARITY_TYPE(0)) dut_odd (
        .clk          (clk),
        .rst          (rst),
        .baud_tick_rx (baud_tick_rx),
        .rx_in        (rx_in_odd),
        .rx_data      (rx_data_o),
        .rx_valid     (rx_valid_o),
        .parity_err   (parity_err_o),
        .frame_err    (frame_err_o),
        .rx_busy      (rx_busy_o)
    );

    always #5 clk = ~clk;

    // 16x tick every third clock.
    int unsigned div_cnt = 0;
    always @(posedge clk) begin
        if (div_cnt == 2) begin
            div_cnt      <= 0;
            baud_tick_rx <= 1'b1;
        end else begin
            div_cnt      <= div_cnt + 1;
            baud_tick_rx <= 1'b0;
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       flip_par;
        logic       stop0;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t qe[$];
    exp_t qo[$];
    int   checks = 0;
    int   passed = 0;
    int   valid_cnt = 0;
    int   valid_cnt_o = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            if (qe.size() == 0) begin
                check("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                e = qe.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rx_valid_o === 1'b1) begin
            valid_cnt_o++;
            if (qo.size() == 0) begin
                check("odd_unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                e = qo.pop_front();
                check("odd_rx_data", {24'd0, rx_data_o}, {24'd0, e.data});
                check("odd_parity_err", {31'd0, parity_err_o}, {31'd0, e.perr});
                check("odd_frame_err", {31'd0, frame_err_o}, {31'd0, e.ferr});
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!baud_tick_rx);
        end
        #1;
    endtask

    task automatic drive(input bit odd, input logic v);
        if (odd) rx_in_odd = v;
        else rx_in = v;
    endtask

    task automatic send_bit(input bit odd, input logic v);
        drive(odd, v);
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop0, input bit odd);
        logic p;
        p = odd ? ~^d : ^d;
        send_bit(odd, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(odd, d[i]);
        send_bit(odd, p ^ flip);
        send_bit(odd, ~stop0);
    endtask

    vec_t tbl[7];
    int   v0;
    logic [7:0] part;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        wait_ticks(4);

        // Table frames sent back-to-back with no idle gap.
        v0 = valid_cnt;
        foreach (tbl[i]) begin
            qe.push_back('{tbl[i].data, tbl[i].exp_perr, tbl[i].exp_ferr});
            send_frame(tbl[i].data, tbl[i].flip_par, tbl[i].stop0, 1'b0);
        end
        wait_ticks(16);
        check("table_pending", qe.size(), 32'd0);
        check("table_valid_count", valid_cnt - v0, 32'd7);

        // Odd-parity receiver.
        qo.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        qo.push_back('{8'h3C, 1'b1, 1'b0});
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        wait_ticks(16);
        check("odd_pending", qo.size(), 32'd0);
        check("odd_valid_count", valid_cnt_o, 32'd2);

        // Stop bit forced low, line then stuck low for three frame times.
        v0 = valid_cnt;
        qe.push_back('{8'h81, 1'b0, 1'b1});
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        wait_ticks(3 * 11 * 16);
        check("stuck_low_busy", {31'd0, rx_busy}, 32'd0);
        drive(1'b0, 1'b1);
        wait_ticks(48);
        check("stuck_pending", qe.size(), 32'd0);
        check("stuck_valid_count", valid_cnt - v0, 32'd1);

        // Short low glitch on an idle line.
        v0 = valid_cnt;
        drive(1'b0, 1'b0);
        wait_ticks(4);
        check("glitch_busy_started", {31'd0, rx_busy}, 32'd1);
        drive(1'b0, 1'b1);
        wait_ticks(5);
        check("glitch_busy_cleared", {31'd0, rx_busy}, 32'd0);
        wait_ticks(32);
        check("glitch_no_valid", valid_cnt - v0, 32'd0);
        check("glitch_data_held", {24'd0, rx_data}, 32'h81);
        check("glitch_ferr_held", {31'd0, frame_err}, 32'd1);

        // Reset in the middle of data bit 3.
        v0 = valid_cnt;
        part = 8'h3C;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, part[i]);
        drive(1'b0, part[3]);
        wait_ticks(8);
        rst = 1'b1;
        #2;
        check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_parity_err", {31'd0, parity_err}, 32'd0);
        check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
        drive(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_ticks(20);
        check("midreset_no_valid", valid_cnt - v0, 32'd0);
        qe.push_back('{8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_ticks(16);
        check("post_reset_pending", qe.size(), 32'd0);
        check("post_reset_valid_count", valid_cnt - v0, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
